mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, width of the address path; data width is fixed at 32.
REQ-002 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Port ex_valid  in  1  EX stage presents a load/store this cycle.
REQ-005 Port ex_we  in  1  1 = store, 0 = load.
REQ-006 Port ex_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 Port ex_sign  in  1  1 = sign-extend load data, 0 = zero-extend.
REQ-008 Port ex_addr  in  ADDR_W  byte address.
REQ-009 Port ex_wdata  in  32  store data, right-aligned.
REQ-010 Port flush  in  1  exception/cancel from the pipeline.
REQ-011 Port stall  out  1  hold the EX stage.
REQ-012 Port mem_valid  out  1  one-cycle completion pulse.
REQ-013 Port mem_rdata  out  32  formatted load data, valid with mem_valid.
REQ-014 Port addr_err  out  1  misaligned or illegal size, valid with mem_valid.
REQ-015 Ports data_sram_req/wr (out 1), size (out 2), addr (out ADDR_W), wstrb (out 4), wdata (out 32) form the SRAM-like request.
REQ-016 Ports data_sram_addr_ok, data_sram_data_ok (in 1) and data_sram_rdata (in 32) form the SRAM-like response.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE; all data_sram_* request outputs SHALL be registered.
REQ-018 Alignment: half requires addr[0]=0, word requires addr[1:0]=00, size 11 is always an error.
REQ-019 IDLE with ex_valid=1, aligned, flush=0: SHALL latch the operation and go to REQ; data_sram_req=1 from the next cycle.
REQ-020 IDLE with ex_valid=1 and misaligned, flush=0: SHALL issue no bus request, pulse mem_valid and addr_err the next cycle, and stay IDLE.
REQ-021 REQ: data_sram_req and all request fields SHALL stay stable until addr_ok=1; on addr_ok go to WAIT, or to DONE if data_ok=1 in the same cycle.
REQ-022 WAIT: on data_ok=1 SHALL capture the formatted rdata and go to DONE.
REQ-023 DONE: mem_valid=1 for exactly one cycle, then return to IDLE; ex_valid in DONE SHALL be ignored.
REQ-024 stall=1 in REQ and WAIT, and combinationally in IDLE when an aligned op is accepted; stall=0 in DONE.
REQ-025 wstrb: byte = 0001<<addr[1:0], half = 0011<<addr[1:0], word = 1111; loads use wstrb=0000.
REQ-026 wdata: byte replicated {4{b}}, half replicated {2{h}}, word unchanged.
REQ-027 Load data SHALL be shifted right by 8*addr[1:0], then extended per ex_sign and size.
REQ-028 flush in REQ or WAIT SHALL set a cancel flag; the bus transaction completes normally, mem_valid is suppressed, and stall drops once the transaction retires.
REQ-029 flush in IDLE SHALL block acceptance; flush in DONE SHALL suppress mem_valid.
REQ-030 data_ok arriving while in REQ before addr_ok SHALL be ignored.

Reset
REQ-031 Reset SHALL force state IDLE, clear the cancel flag, and set all outputs to 0, including mem_rdata=0; this applies mid-transaction with no completion pulse.

Structure
REQ-032 Package mem_ctrl_pkg SHALL hold the size encodings (BYTE/HALF/WORD), the FSM state enum, and the strobe constants.
REQ-033 Lane formatting (wstrb/wdata replication and load extract/extend) SHALL be one combinational sub-module, lsu_lane_fmt.

Verification
REQ-034 LW addr 0x100, addr_ok after 2 cycles, data_ok 3 cycles later with rdata 0x8899AABB -> mem_rdata 0x8899AABB, one mem_valid pulse, stall high throughout.
REQ-035 LB sign, addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LHU addr 0x102, same rdata -> 0x00008011.
REQ-036 SB addr 0x101, wdata 0x000000A5 -> wstrb 0010, data_sram_wdata 0xA5A5A5A5, wr=1.
REQ-037 LW addr 0x102 -> no data_sram_req, addr_err=1 and mem_valid=1 next cycle.
REQ-038 flush in WAIT -> transaction finishes on data_ok, mem_valid stays 0, FSM returns to IDLE.
REQ-039 reset asserted in REQ -> data_sram_req=0 immediately, state IDLE, no mem_valid.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the load/store access controller: access sizes,
// controller states, byte-strobe patterns and the alignment rule.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting: store strobes/replicated write data from the
// request fields, and extract/extend of returned load data.
import mem_ctrl_pkg::*;

module lsu_lane_fmt (
    input  logic        st_we,
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata_fmt,
    input  logic [1:0]  ld_size,
    input  logic        ld_sign,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_wstrb     = STRB_NONE;
        st_wdata_fmt = '0;
        if (st_we) begin
            case (st_size)
                SZ_BYTE: begin
                    st_wstrb     = STRB_BYTE << st_addr_lo;
                    st_wdata_fmt = {4{st_wdata[7:0]}};
                end
                SZ_HALF: begin
                    st_wstrb     = STRB_HALF << st_addr_lo;
                    st_wdata_fmt = {2{st_wdata[15:0]}};
                end
                default: begin
                    st_wstrb     = STRB_WORD;
                    st_wdata_fmt = st_wdata;
                end
            endcase
        end
    end

    always_comb begin
        ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_sign & ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data = {{16{ld_sign & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// EX-stage load/store controller driving an SRAM-like data bus: one
// outstanding access, registered request, one-cycle completion pulse.
import mem_ctrl_pkg::*;

module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic [1:0]        ex_size,
    input  logic              ex_sign,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              mem_valid,
    output logic [31:0]       mem_rdata,
    output logic              addr_err,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [3:0]        data_sram_wstrb,
    output logic [31:0]       data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata
);

    state_e            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              aligned;
    logic [3:0]        fmt_wstrb;
    logic [31:0]       fmt_wdata;
    logic [31:0]       ld_data;

    // Store formatting works on the live EX fields so the request can be
    // registered fully formed; load formatting uses the latched operation.
    lsu_lane_fmt u_lane_fmt (
        .st_we        (ex_we),
        .st_size      (ex_size),
        .st_addr_lo   (ex_addr[1:0]),
        .st_wdata     (ex_wdata),
        .st_wstrb     (fmt_wstrb),
        .st_wdata_fmt (fmt_wdata),
        .ld_size      (size_q),
        .ld_sign      (sign_q),
        .ld_addr_lo   (addr_q[1:0]),
        .ld_rdata     (data_sram_rdata),
        .ld_data      (ld_data)
    );

    assign aligned = is_aligned(ex_size, ex_addr[1:0]);

    always_comb begin
        state_d   = state_q;
        cancel_d  = cancel_q;
        req_d     = req_q;
        wr_d      = wr_q;
        size_d    = size_q;
        sign_d    = sign_q;
        addr_d    = addr_q;
        wstrb_d   = wstrb_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        stall     = 1'b0;
        mem_valid = err_q;

        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (ex_valid && !flush) begin
                    if (aligned) begin
                        stall   = 1'b1;
                        state_d = REQ;
                        req_d   = 1'b1;
                        wr_d    = ex_we;
                        size_d  = ex_size;
                        sign_d  = ex_sign;
                        addr_d  = ex_addr;
                        wstrb_d = fmt_wstrb;
                        wdata_d = fmt_wdata;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (flush) cancel_d = 1'b1;
                // data_ok before the address handshake belongs to nobody.
                if (data_sram_addr_ok) begin
                    req_d = 1'b0;
                    if (data_sram_data_ok) begin
                        state_d = DONE;
                        rdata_d = wr_q ? 32'd0 : ld_data;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (flush) cancel_d = 1'b1;
                if (data_sram_data_ok) begin
                    state_d = DONE;
                    rdata_d = wr_q ? 32'd0 : ld_data;
                end
            end
            DONE: begin
                mem_valid = !cancel_q && !flush;
                state_d   = IDLE;
                cancel_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            addr_q   <= '0;
            wstrb_q  <= STRB_NONE;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign mem_rdata       = rdata_q;
    assign addr_err        = err_q;
    assign data_sram_req   = req_q;
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-level model checked every
// cycle, plus literal expectations on each directed access.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0, ex_we = 1'b0, ex_sign = 1'b0, flush = 1'b0;
    logic [1:0]  ex_size = 2'b00;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic        stall, mem_valid, addr_err;
    logic [31:0] mem_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = '0;

    int n_pass = 0, n_total = 0;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_size(ex_size), .ex_sign(ex_sign),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush),
        .stall(stall), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .addr_err(addr_err),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
        .data_sram_rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level reference ----------------
    function automatic logic legal(input logic [1:0] sz, input logic [31:0] a);
        int nbytes;
        if (sz == 2'b11) return 1'b0;
        nbytes = 1 << sz;
        return (a % nbytes) == 0;
    endfunction

    function automatic logic [3:0] exp_strb(input logic we, input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] s = 4'b0000;
        int nbytes = 1 << sz;
        int off = a % 4;
        if (!we) return 4'b0000;
        for (int k = 0; k < nbytes; k++) s[off + k] = 1'b1;
        return s;
    endfunction

    // Every lane k carries byte (k mod size) of the right-aligned datum.
    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] v;
        int nbytes = 1 << sz;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = wd[8*(k % nbytes) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v = '0;
        int nbytes = 1 << sz;
        int off = a % 4;
        for (int k = 0; k < nbytes; k++) v[8*k +: 8] = rd[8*(off + k) +: 8];
        if (sg && v[8*nbytes - 1])
            for (int k = nbytes; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    logic        m_busy = 0, m_addr_done = 0, m_done = 0, m_cancel = 0, m_err = 0, m_rd_valid = 0;
    logic        e_wr = 0, e_sign = 0;
    logic [1:0]  e_size = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, m_rdata = 0;
    logic [3:0]  e_strb = 0;

    always @(posedge clk or posedge reset) begin
        logic fin;
        fin = 1'b0;
        if (reset) begin
            m_busy = 0; m_addr_done = 0; m_done = 0; m_cancel = 0; m_err = 0; m_rd_valid = 0;
        end else begin
            m_err = 1'b0;
            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_busy) begin
                if (ex_valid && !flush) begin
                    if (legal(ex_size, ex_addr)) begin
                        m_busy = 1; m_addr_done = 0; m_cancel = 0;
                        e_wr = ex_we; e_size = ex_size; e_sign = ex_sign; e_addr = ex_addr;
                        e_strb = exp_strb(ex_we, ex_size, ex_addr);
                        e_wdata = exp_wdata(ex_size, ex_wdata);
                    end else begin
                        m_err = 1'b1;
                        m_rd_valid = 1'b0;
                    end
                end
            end else begin
                if (flush) m_cancel = 1'b1;
                if (!m_addr_done) begin
                    if (addr_ok) begin
                        m_addr_done = 1'b1;
                        fin = data_ok;
                    end
                end else begin
                    fin = data_ok;
                end
                if (fin) begin
                    m_busy = 0; m_done = 1;
                    m_rd_valid = !e_wr;
                    m_rdata = exp_load(e_size, e_sign, e_addr, rdata);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic x_stall, x_req, x_mv;
        x_req   = m_busy && !m_addr_done;
        x_stall = !reset && (m_busy || (!m_done && ex_valid && !flush && legal(ex_size, ex_addr)));
        x_mv    = m_err || (m_done && !m_cancel && !flush);
        chk("stall", {31'd0, stall}, {31'd0, x_stall});
        chk("req", {31'd0, data_sram_req}, {31'd0, x_req});
        chk("mem_valid", {31'd0, mem_valid}, {31'd0, x_mv});
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
        if (x_mv && !m_err && m_rd_valid) chk("mem_rdata", mem_rdata, m_rdata);
        if (x_req) begin
            chk("req_wr", {31'd0, data_sram_wr}, {31'd0, e_wr});
            chk("req_size", {30'd0, data_sram_size}, {30'd0, e_size});
            chk("req_addr", data_sram_addr, e_addr);
            chk("req_wstrb", {28'd0, data_sram_wstrb}, {28'd0, e_strb});
            if (e_wr) chk("req_wdata", data_sram_wdata, e_wdata);
        end
        if (reset) begin
            chk("rst_rdata", mem_rdata, 32'd0);
            chk("rst_fields", {data_sram_wr, data_sram_size, data_sram_wstrb},  7'd0);
            chk("rst_addr", data_sram_addr, 32'd0);
            chk("rst_wdata", data_sram_wdata, 32'd0);
        end
    end

    // ---------------- observation for literal pins ----------------
    int          pulses = 0;
    logic [31:0] last_rdata = 0, last_wdata = 0;
    logic        last_err = 0, saw_req = 0, last_wr = 0;
    logic [3:0]  last_strb = 0;

    always @(negedge clk) begin
        if (mem_valid === 1'b1) begin
            pulses++; last_rdata = mem_rdata; last_err = addr_err;
        end
        if (data_sram_req === 1'b1) begin
            saw_req = 1'b1; last_strb = data_sram_wstrb; last_wdata = data_sram_wdata; last_wr = data_sram_wr;
        end
    end

    int base;

    task automatic start(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        base = pulses; saw_req = 1'b0;
        ex_valid = 1; ex_we = we; ex_size = sz; ex_sign = sg; ex_addr = a; ex_wdata = wd;
        @(posedge clk); #1;
        ex_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // Full bus access: alat cycles before addr_ok, data_ok dlat cycles after
    // it (0 = same cycle); optional flush in WAIT / DONE, optional early data_ok.
    task automatic bus_op(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int alat, input int dlat, input logic [31:0] rd,
                          input logic fl_wait, input logic fl_done, input logic spur);
        start(we, sz, sg, a, wd);
        for (int i = 0; i < alat; i++) begin
            data_ok = spur && (i == 0); rdata = 32'hDEAD_BEEF;
            @(posedge clk); #1;
        end
        data_ok = 0; addr_ok = 1;
        if (dlat == 0) begin data_ok = 1; rdata = rd; end
        @(posedge clk); #1;
        addr_ok = 0; data_ok = 0;
        if (dlat > 0) begin
            for (int i = 1; i < dlat; i++) begin
                flush = fl_wait && (i == 1);
                @(posedge clk); #1;
            end
            flush = 0; data_ok = 1; rdata = rd;
            @(posedge clk); #1;
            data_ok = 0;
        end
        flush = fl_done;
        @(posedge clk); #1;
        flush = 0;
        idle(2);
    endtask

    task automatic pin(input string nm, input int n_exp, input logic chk_rd,
                       input logic [31:0] rd_exp, input logic err_exp);
        chk({nm, "_pulses"}, pulses - base, n_exp);
        if (n_exp > 0) chk({nm, "_err"}, {31'd0, last_err}, {31'd0, err_exp});
        if (chk_rd) chk({nm, "_rdata"}, last_rdata, rd_exp);
    endtask

    initial begin
        idle(3);
        #2;
        chk("reset_req", {31'd0, data_sram_req}, 32'd0);
        chk("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        idle(2);

        bus_op(0, 2'b10, 0, 32'h100, 0, 2, 3, 32'h8899AABB, 0, 0, 0);
        pin("lw_100", 1, 1, 32'h8899AABB, 0);
        bus_op(0, 2'b00, 1, 32'h103, 0, 0, 1, 32'h80112233, 0, 0, 0);
        pin("lb_103", 1, 1, 32'hFFFFFF80, 0);
        bus_op(0, 2'b01, 0, 32'h102, 0, 1, 0, 32'h80112233, 0, 0, 0);
        pin("lhu_102", 1, 1, 32'h00008011, 0);
        bus_op(0, 2'b00, 0, 32'h101, 0, 1, 1, 32'h80112233, 0, 0, 0);
        pin("lbu_101", 1, 1, 32'h00000022, 0);

        bus_op(1, 2'b00, 0, 32'h101, 32'h000000A5, 1, 1, 0, 0, 0, 0);
        pin("sb_101", 1, 0, 0, 0);
        chk("sb_wstrb", {28'd0, last_strb}, 32'h2);
        chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
        chk("sb_wr", {31'd0, last_wr}, 32'd1);
        bus_op(1, 2'b01, 0, 32'h10E, 32'h1234BEEF, 0, 2, 0, 0, 0, 0);
        chk("sh_wstrb", {28'd0, last_strb}, 32'hC);
        chk("sh_wdata", last_wdata, 32'hBEEFBEEF);
        bus_op(1, 2'b10, 0, 32'h300, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0);
        chk("sw_wstrb", {28'd0, last_strb}, 32'hF);

        start(0, 2'b10, 0, 32'h102, 0);
        idle(2);
        pin("lw_misalign", 1, 0, 0, 1);
        chk("lw_misalign_noreq", {31'd0, saw_req}, 32'd0);
        start(0, 2'b11, 0, 32'h200, 0);
        idle(2);
        pin("size_illegal", 1, 0, 0, 1);

        bus_op(0, 2'b10, 0, 32'h200, 0, 1, 3, 32'h11111111, 1, 0, 0);
        pin("flush_wait", 0, 0, 0, 0);
        bus_op(0, 2'b10, 0, 32'h204, 0, 0, 1, 32'h22222222, 0, 1, 0);
        pin("flush_done", 0, 0, 0, 0);
        base = pulses; saw_req = 0;
        ex_valid = 1; ex_we = 0; ex_size = 2'b10; ex_addr = 32'h208; flush = 1;
        @(posedge clk); #1;
        ex_valid = 0; flush = 0;
        idle(2);
        pin("flush_idle", 0, 0, 0, 0);
        chk("flush_idle_noreq", {31'd0, saw_req}, 32'd0);

        bus_op(0, 2'b01, 1, 32'h106, 0, 2, 2, 32'h9ABC1234, 0, 0, 1);
        pin("lh_spurious", 1, 1, 32'hFFFF9ABC, 0);

        start(0, 2'b10, 0, 32'h400, 0);
        @(posedge clk); #1;
        reset = 1;
        #1;
        chk("rst_in_req_req", {31'd0, data_sram_req}, 32'd0);
        chk("rst_in_req_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        idle(3);
        pin("rst_in_req", 0, 0, 0, 0);

        bus_op(0, 2'b10, 0, 32'h104, 0, 1, 1, 32'h01020304, 0, 0, 0);
        pin("lw_after_rst", 1, 1, 32'h01020304, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
